// File: rtl/snn_pkg.sv
// Shared default constants and the saturating leak+integrate arithmetic for the LIF neuron layer.
package snn_pkg;

    localparam int unsigned DEF_IN_W       = 8;
    localparam int unsigned DEF_POT_W      = 12;
    localparam int unsigned DEF_LEAK_SHIFT = 3;
    localparam int unsigned DEF_REFRAC     = 4;
    localparam int unsigned DEF_THRESH_RST = 200;
    localparam int unsigned DEF_CNT_W      = 8;

    // pot - (pot >> shift) + cur, clamped to the largest pot_w-bit value
    function automatic logic [31:0] leak_add_sat(
        input logic [31:0] pot,
        input logic [31:0] cur,
        input int unsigned shift,
        input int unsigned pot_w
    );
        logic [32:0] sum;
        logic [31:0] pmax;
        pmax = (32'(1) << pot_w) - 32'(1);
        sum  = 33'(pot - (pot >> shift)) + 33'(cur);
        return (sum > 33'(pmax)) ? pmax : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_core.sv
// Single leaky-integrate-and-fire neuron with refractory counter and wrapping spike counter.
module lif_core
    import snn_pkg::*;
#(
    parameter int unsigned IN_W       = DEF_IN_W,
    parameter int unsigned POT_W      = DEF_POT_W,
    parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int unsigned REFRAC     = DEF_REFRAC,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IN_W-1:0]  in_cur,
    input  logic [POT_W-1:0] thresh,
    input  logic             cnt_clr,
    output logic             spike,
    output logic [POT_W-1:0] pot,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [POT_W-1:0] pot_q, pot_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             spike_q, spike_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POT_W-1:0] nxt;
    logic             fire;

    // Next-state: refractory countdown, otherwise integrate and compare to threshold
    always_comb begin
        pot_d   = pot_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        nxt     = POT_W'(leak_add_sat(32'(pot_q), 32'(in_cur), LEAK_SHIFT, POT_W));
        if (en) begin
            if (rc_q != '0) begin
                rc_d  = rc_q - RC_W'(1);
                pot_d = '0;
            end else if (nxt >= thresh) begin
                fire  = 1'b1;
                pot_d = '0;
                rc_d  = RC_W'(REFRAC);
            end else begin
                pot_d = nxt;
            end
        end
        spike_d = fire;
        // A clear coinciding with a fresh spike leaves the count at zero
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pot_q   <= '0;
            rc_q    <= '0;
            spike_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pot_q   <= pot_d;
            rc_q    <= rc_d;
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
        end
    end

    assign spike = spike_q;
    assign pot   = pot_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/lif_neuron_layer.sv
// Layer of independent LIF neurons sharing a programmable threshold, with a state monitor mux.
module lif_neuron_layer
    import snn_pkg::*;
#(
    parameter int unsigned N_NEUR     = 4,
    parameter int unsigned IN_W       = DEF_IN_W,
    parameter int unsigned POT_W      = DEF_POT_W,
    parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int unsigned REFRAC     = DEF_REFRAC,
    parameter int unsigned THRESH_RST = DEF_THRESH_RST,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    localparam int unsigned SEL_W     = (N_NEUR > 1) ? $clog2(N_NEUR) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [N_NEUR*IN_W-1:0] in_cur,
    input  logic                   thr_we,
    input  logic [POT_W-1:0]       thr_data,
    input  logic                   cnt_clr,
    input  logic [SEL_W-1:0]       mon_sel,
    output logic [N_NEUR-1:0]      spike,
    output logic [POT_W-1:0]       mon_pot,
    output logic [CNT_W-1:0]       mon_cnt
);

    logic [POT_W-1:0] thresh_q, thresh_d;
    logic [POT_W-1:0] pot_arr [N_NEUR];
    logic [CNT_W-1:0] cnt_arr [N_NEUR];

    // Neurons see the old threshold on the edge a new one is written
    always_comb begin
        thresh_d = thresh_q;
        if (thr_we) begin
            thresh_d = thr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_q <= POT_W'(THRESH_RST);
        end else begin
            thresh_q <= thresh_d;
        end
    end

    for (genvar g = 0; g < N_NEUR; g++) begin : g_neur
        lif_core #(
            .IN_W       (IN_W),
            .POT_W      (POT_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC),
            .CNT_W      (CNT_W)
        ) u_core (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .in_cur  (in_cur[g*IN_W +: IN_W]),
            .thresh  (thresh_q),
            .cnt_clr (cnt_clr),
            .spike   (spike[g]),
            .pot     (pot_arr[g]),
            .cnt     (cnt_arr[g])
        );
    end

    // Out-of-range selects read as zero
    always_comb begin
        mon_pot = '0;
        mon_cnt = '0;
        for (int i = 0; i < N_NEUR; i++) begin
            if (mon_sel == SEL_W'(i)) begin
                mon_pot = pot_arr[i];
                mon_cnt = cnt_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Randomised and directed checks of lif_neuron_layer against an arithmetic reference model.
module tb_lif_neuron_layer;

    localparam int unsigned N    = 4;
    localparam int unsigned PMAX = 4095;
    localparam int unsigned THR0 = 200;
    localparam int unsigned RFR  = 4;

    logic        clk = 1'b0;
    logic        reset, en, thr_we, cnt_clr;
    logic [31:0] in_cur;
    logic [11:0] thr_data;
    logic [1:0]  mon_sel;
    logic [3:0]  spike;
    logic [11:0] mon_pot;
    logic [7:0]  mon_cnt;

    logic        b_reset, b_en, b_thr_we, b_cnt_clr;
    logic [23:0] b_in;
    logic [8:0]  b_thr_data;
    logic [1:0]  b_mon_sel;
    logic [2:0]  b_spike;
    logic [8:0]  b_mon_pot;
    logic [7:0]  b_mon_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned m_pot [N];
    int unsigned m_rc  [N];
    int unsigned m_cnt [N];
    logic [3:0]  m_spk;
    int unsigned m_thr;

    always #10 clk = ~clk;

    lif_neuron_layer #(
        .N_NEUR(4), .IN_W(8), .POT_W(12), .LEAK_SHIFT(3),
        .REFRAC(4), .THRESH_RST(200), .CNT_W(8)
    ) u_dut (
        .clk(clk), .reset(reset), .en(en), .in_cur(in_cur),
        .thr_we(thr_we), .thr_data(thr_data), .cnt_clr(cnt_clr),
        .mon_sel(mon_sel), .spike(spike), .mon_pot(mon_pot), .mon_cnt(mon_cnt)
    );

    lif_neuron_layer #(
        .N_NEUR(3), .IN_W(8), .POT_W(9), .LEAK_SHIFT(3),
        .REFRAC(0), .THRESH_RST(511), .CNT_W(8)
    ) u_sat (
        .clk(clk), .reset(b_reset), .en(b_en), .in_cur(b_in),
        .thr_we(b_thr_we), .thr_data(b_thr_data), .cnt_clr(b_cnt_clr),
        .mon_sel(b_mon_sel), .spike(b_spike), .mon_pot(b_mon_pot), .mon_cnt(b_mon_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic applied per neuron at one clock edge
    task automatic model_step(input logic r, input logic e, input logic [31:0] cur,
                              input logic we, input logic [11:0] td, input logic clr);
        int unsigned nxt;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_pot[i] = 0; m_rc[i] = 0; m_cnt[i] = 0;
            end
            m_spk = '0;
            m_thr = THR0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            m_spk[i] = 1'b0;
            if (e) begin
                if (m_rc[i] > 0) begin
                    m_rc[i]--;
                    m_pot[i] = 0;
                end else begin
                    nxt = m_pot[i] - m_pot[i] / 8 + ((cur >> (8 * i)) & 32'hFF);
                    if (nxt > PMAX) nxt = PMAX;
                    if (nxt >= m_thr) begin
                        m_spk[i] = 1'b1;
                        m_pot[i] = 0;
                        m_rc[i]  = RFR;
                    end else begin
                        m_pot[i] = nxt;
                    end
                end
            end
            if (clr) m_cnt[i] = 0;
            else if (m_spk[i]) m_cnt[i] = (m_cnt[i] + 1) % 256;
        end
        if (we) m_thr = td;
    endtask

    task automatic cyc(input logic r, input logic e, input logic [31:0] cur,
                       input logic we, input logic [11:0] td, input logic clr);
        @(negedge clk);
        reset = r; en = e; in_cur = cur; thr_we = we; thr_data = td; cnt_clr = clr;
        model_step(r, e, cur, we, td, clr);
        @(posedge clk);
        #1;
        check_eq("spike", 32'(spike), 32'(m_spk));
        for (int i = 0; i < N; i++) begin
            mon_sel = 2'(i);
            #1;
            check_eq($sformatf("pot%0d", i), 32'(mon_pot), m_pot[i]);
            check_eq($sformatf("cnt%0d", i), 32'(mon_cnt), m_cnt[i]);
        end
        mon_sel = 2'd0;
        #1;
    endtask

    task automatic b_cyc(input logic r, input logic we, input logic [8:0] td, input logic clr);
        @(negedge clk);
        b_reset = r; b_en = 1'b1; b_in = 24'hFFFFFF;
        b_thr_we = we; b_thr_data = td; b_cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    int unsigned plan_pot [5] = '{50, 94, 133, 167, 197};

    initial begin
        reset = 1'b1; en = 1'b0; in_cur = '0; thr_we = 1'b0; thr_data = '0;
        cnt_clr = 1'b0; mon_sel = '0;
        b_reset = 1'b1; b_en = 1'b0; b_in = '0; b_thr_we = 1'b0; b_thr_data = '0;
        b_cnt_clr = 1'b0; b_mon_sel = '0;

        cyc(1, 1, 32'hFFFFFFFF, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Steady firing: period 10, three spikes in 30 updates
        for (int k = 1; k <= 30; k++) begin
            cyc(0, 1, 32'd50, 0, 0, 0);
            if (k <= 5) check_eq("plan_pot", 32'(mon_pot), plan_pot[k-1]);
            if (k == 6 || k == 16) check_eq("plan_spike", 32'(spike[0]), 1);
        end
        check_eq("plan_cnt3", 32'(mon_cnt), 3);

        // Threshold write takes effect only after the writing edge
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'd50, 0, 0, 0);
        cyc(0, 1, 32'd50, 0, 0, 0);
        cyc(0, 1, 32'd50, 1, 12'd100, 0);
        check_eq("thr_old", 32'(spike[0]), 0);
        check_eq("thr_old_pot", 32'(mon_pot), 133);
        cyc(0, 1, 32'd50, 0, 0, 0);
        check_eq("thr_new", 32'(spike[0]), 1);
        cyc(0, 1, 0, 1, 12'd200, 0);

        // Enable hold, then reset in the middle of a refractory period
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 32'd50, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 32'd50, 0, 0, 0);
        check_eq("en_hold", 32'(mon_pot), 133);
        cyc(0, 1, 32'd50, 0, 0, 0);
        check_eq("en_resume", 32'(mon_pot), 167);
        cyc(0, 1, 32'd50, 0, 0, 0);
        cyc(0, 1, 32'd50, 0, 0, 0);
        check_eq("pre_rst_spike", 32'(spike[0]), 1);
        cyc(0, 1, 32'd50, 0, 0, 0);
        cyc(0, 0, 32'd50, 0, 0, 0);
        cyc(0, 1, 32'd50, 0, 0, 0);
        cyc(1, 1, 32'd50, 0, 0, 0);
        cyc(0, 1, 32'd50, 0, 0, 0);
        check_eq("post_rst_pot", 32'(mon_pot), 50);

        // Random traffic across all inputs
        for (int k = 0; k < 800; k++) begin
            logic        r, e, we, clr;
            logic [31:0] cur;
            logic [11:0] td;
            int unsigned sel;
            r   = ($urandom_range(0, 99) < 2);
            e   = ($urandom_range(0, 99) < 85);
            we  = ($urandom_range(0, 99) < 5);
            clr = ($urandom_range(0, 99) < 3);
            cur = $urandom;
            if ($urandom_range(0, 1) == 0) cur = cur & 32'h3F3F3F3F;
            sel = $urandom_range(0, 9);
            td  = (sel == 0) ? 12'd0 : (sel == 1) ? 12'd4095 : 12'($urandom_range(0, 600));
            cyc(r, e, cur, we, td, clr);
        end

        // Saturation on the narrow instance, then wrap and clear at thresh 0
        b_cyc(1, 0, 0, 0);
        b_cyc(0, 0, 0, 0);
        check_eq("sat_pot1", 32'(b_mon_pot), 255);
        b_cyc(0, 0, 0, 0);
        check_eq("sat_pot2", 32'(b_mon_pot), 479);
        b_cyc(0, 0, 0, 0);
        check_eq("sat_spike", 32'(b_spike), 7);
        check_eq("sat_pot0", 32'(b_mon_pot), 0);
        b_cyc(0, 1, 9'd0, 0);
        check_eq("sat_thr_old", 32'(b_spike), 0);
        for (int k = 0; k < 255; k++) begin
            b_cyc(0, 0, 0, 0);
            check_eq("wrap_spike", 32'(b_spike), 7);
        end
        for (int i = 0; i < 3; i++) begin
            b_mon_sel = 2'(i);
            #1;
            check_eq($sformatf("wrap_cnt%0d", i), 32'(b_mon_cnt), 0);
        end
        b_cyc(0, 0, 0, 1);
        check_eq("clr_spike", 32'(b_spike), 7);
        check_eq("clr_cnt", 32'(b_mon_cnt), 0);
        b_cyc(0, 0, 0, 0);
        check_eq("after_clr_cnt", 32'(b_mon_cnt), 1);
        b_mon_sel = 2'd3;
        b_in = 24'h0;
        #1;
        check_eq("oob_pot", 32'(b_mon_pot), 0);
        check_eq("oob_cnt", 32'(b_mon_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
